move_sequencer: RTL and testbench

- Upstream stage of the playfield logic: turns raw player buttons and a gravity timer into the single-cycle move strobes (leftTrue/rightTrue/downTrue/rotateTrue) and the 3-bit next-piece code (blockType) that the playfield consumes.
- Synchronises and edge-detects the buttons, runs a score-scaled gravity counter, and arbitrates pending requests so that at most one strobe is asserted per cycle.
- Generates pseudo-random piece codes with an LFSR.

---
 rtl/move_sequencer_if.sv | 33 +++
 rtl/move_sequencer.sv | 175 +++++++++++++++++
 tb/tb_move_sequencer.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/move_sequencer_if.sv
// move_sequencer_if: groups the player-side inputs and the playfield-facing outputs of the
// move sequencer.
//   btnLeft/btnRight/btnRotate/btnDown : raw asynchronous button levels
//   pause                              : freeze gravity and strobes while high
//   score                              : current score, drives the speed level
//   leftTrue/rightTrue/downTrue/rotateTrue : one-cycle move strobes
//   blockType                          : next piece code, 0..5
//   level                              : current speed level, 0..3
// master: the side that drives buttons/pause/score; slave: the sequencer itself.
interface move_sequencer_if;
  logic        btnLeft;
  logic        btnRight;
  logic        btnRotate;
  logic        btnDown;
  logic        pause;
  logic [31:0] score;
  logic        leftTrue;
  logic        rightTrue;
  logic        downTrue;
  logic        rotateTrue;
  logic [2:0]  blockType;
  logic [1:0]  level;

  modport master (
    output btnLeft, btnRight, btnRotate, btnDown, pause, score,
    input  leftTrue, rightTrue, downTrue, rotateTrue, blockType, level
  );

  modport slave (
    input  btnLeft, btnRight, btnRotate, btnDown, pause, score,
    output leftTrue, rightTrue, downTrue, rotateTrue, blockType, level
  );
endinterface

// File: rtl/move_sequencer.sv
// move_sequencer: turns raw buttons and a score-scaled gravity timer into single-cycle move
// strobes for the playfield, at most one per cycle with an idle cycle between strobes, and
// produces pseudo-random piece codes from a 16-bit LFSR.
// Ports:
//   clock : system clock, all state on posedge
//   reset : synchronous active-low reset
//   bus   : move_sequencer_if.slave (buttons, pause, score in; strobes, blockType, level out)
// Optional feature: define AUTO_REPEAT_EN to re-trigger left/right while the button is held.
module move_sequencer #(
  parameter int unsigned GRAVITY_DIV = 25000000,
  parameter int unsigned SOFT_DIV    = 2500000,
  parameter int unsigned LEVEL_STEP  = 10,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input logic             clock,
  input logic             reset,
  move_sequencer_if.slave bus
);

  // Button / pending-flag bit positions
  localparam int unsigned IdxLeft   = 0;
  localparam int unsigned IdxRight  = 1;
  localparam int unsigned IdxRotate = 2;
  localparam int unsigned IdxDown   = 3;

  typedef enum logic [1:0] {StIdle, StIssue, StGap} state_e;

  state_e      state_q, state_d;
  logic [3:0]  btn;
  logic [3:0]  meta_q, sync_q, prev_q;
  logic [3:0]  btn_edge;
  logic [3:0]  pend_q, pend_d, pend_set, pend_clr;
  logic [3:0]  strobe_q, strobe_d;
  logic [31:0] grav_cnt_q, grav_cnt_d;
  logic [31:0] period;
  logic        grav_fire;
  logic [1:0]  level_q, level_d;
  logic [15:0] lfsr_q;
  logic        lfsr_fb;
  logic [2:0]  block_q;
  logic [1:0]  rep_set;

  assign btn      = {bus.btnDown, bus.btnRotate, bus.btnRight, bus.btnLeft};
  assign btn_edge = sync_q & ~prev_q;

  // Level from score using constant thresholds only
  always_comb begin
    level_d = 2'd0;
    if (bus.score >= 32'(3 * LEVEL_STEP)) begin
      level_d = 2'd3;
    end else if (bus.score >= 32'(2 * LEVEL_STEP)) begin
      level_d = 2'd2;
    end else if (bus.score >= 32'(LEVEL_STEP)) begin
      level_d = 2'd1;
    end
  end

  // Gravity: >= keeps a mid-count period shrink from running the counter past the limit
  always_comb begin
    period     = sync_q[IdxDown] ? 32'(SOFT_DIV) : (32'(GRAVITY_DIV) >> level_q);
    grav_cnt_d = grav_cnt_q;
    grav_fire  = 1'b0;
    if (!bus.pause) begin
      if (grav_cnt_q >= period - 32'd1) begin
        grav_fire  = 1'b1;
        grav_cnt_d = '0;
      end else begin
        grav_cnt_d = grav_cnt_q + 32'd1;
      end
    end
  end

`ifdef AUTO_REPEAT_EN
  localparam int unsigned RepDiv  = (GRAVITY_DIV / 64 == 0) ? 1 : GRAVITY_DIV / 64;
  localparam int unsigned HoldMax = 16 * RepDiv - 1;

  logic [31:0] hold_q [2];

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      rep_set[i] = sync_q[i] && (hold_q[i] >= 32'(HoldMax));
    end
  end

  // After the first repeat, reload so the next one lands RepDiv cycles later
  always_ff @(posedge clock) begin
    for (int i = 0; i < 2; i++) begin
      if (!reset || !sync_q[i]) begin
        hold_q[i] <= '0;
      end else if (rep_set[i]) begin
        hold_q[i] <= 32'(15 * RepDiv);
      end else begin
        hold_q[i] <= hold_q[i] + 32'd1;
      end
    end
  end
`else
  assign rep_set = 2'b00;
`endif

  // Set wins over clear so an event coinciding with ISSUE is never lost
  always_comb begin
    pend_set          = btn_edge;
    pend_set[IdxDown] = btn_edge[IdxDown] | grav_fire;
    pend_set[1:0]     = pend_set[1:0] | rep_set;
    pend_d            = (pend_q & ~pend_clr) | pend_set;
  end

  // Strobe is loaded on the IDLE->ISSUE edge, so it is high exactly while in ISSUE
  always_comb begin
    state_d  = state_q;
    strobe_d = '0;
    pend_clr = '0;
    unique case (state_q)
      StIdle: begin
        if (!bus.pause && (pend_q != 4'b0000)) begin
          state_d = StIssue;
          if (pend_q[IdxDown]) begin
            strobe_d[IdxDown] = 1'b1;
          end else if (pend_q[IdxRight]) begin
            strobe_d[IdxRight] = 1'b1;
          end else if (pend_q[IdxLeft]) begin
            strobe_d[IdxLeft] = 1'b1;
          end else begin
            strobe_d[IdxRotate] = 1'b1;
          end
          pend_clr = strobe_d;
        end
      end
      StIssue: state_d = StGap;
      StGap:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Taps 16,14,13,11
  assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= StIdle;
      meta_q     <= '0;
      sync_q     <= '0;
      prev_q     <= '0;
      pend_q     <= '0;
      strobe_q   <= '0;
      grav_cnt_q <= '0;
      level_q    <= '0;
      lfsr_q     <= LFSR_SEED;
      block_q    <= '0;
    end else begin
      state_q    <= state_d;
      meta_q     <= btn;
      sync_q     <= meta_q;
      prev_q     <= sync_q;
      pend_q     <= pend_d;
      strobe_q   <= strobe_d;
      grav_cnt_q <= grav_cnt_d;
      level_q    <= level_d;
      lfsr_q     <= {lfsr_q[14:0], lfsr_fb};
      // Codes 6 and 7 are skipped by holding the previous piece
      if (lfsr_q[2:0] < 3'd6) begin
        block_q <= lfsr_q[2:0];
      end
    end
  end

  assign bus.leftTrue   = strobe_q[IdxLeft];
  assign bus.rightTrue  = strobe_q[IdxRight];
  assign bus.rotateTrue = strobe_q[IdxRotate];
  assign bus.downTrue   = strobe_q[IdxDown];
  assign bus.blockType  = block_q;
  assign bus.level      = level_q;

endmodule

// File: tb/tb_move_sequencer.sv
// Directed bench for move_sequencer (GRAVITY_DIV=64, SOFT_DIV=8, LEVEL_STEP=10).
module tb_move_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_bad = 0;

  move_sequencer_if bus ();

  move_sequencer #(
    .GRAVITY_DIV (64),
    .SOFT_DIV    (8),
    .LEVEL_STEP  (10),
    .LFSR_SEED   (16'hACE1)
  ) u_dut (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  function automatic logic [3:0] strb();
    return {bus.downTrue, bus.rotateTrue, bus.rightTrue, bus.leftTrue};
  endfunction

  // Cycles until the next downTrue, or -1 if none within the bound
  task automatic wait_down(output int cyc);
    cyc = -1;
    for (int i = 1; i <= 300; i++) begin
      tick();
      if (bus.downTrue) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic test_reset;
    bus.score = 32'd35;
    do_reset();
    n_cmp++;
    if (strb() !== 4'b0000) begin
      n_bad++; $display("FAIL reset_strobes: got %b expected 0000", strb());
    end
    n_cmp++;
    if (bus.blockType !== 3'd0) begin
      n_bad++; $display("FAIL reset_block: got %0d expected 0", bus.blockType);
    end
    n_cmp++;
    if (bus.level !== 2'd0) begin
      n_bad++; $display("FAIL reset_level: got %0d expected 0", bus.level);
    end
    tick();
    n_cmp++;
    if (bus.level !== 2'd3) begin
      n_bad++; $display("FAIL level_after_reset: got %0d expected 3", bus.level);
    end
    n_cmp++;
    if (bus.blockType !== 3'd1) begin
      n_bad++; $display("FAIL block_first: got %0d expected 1", bus.blockType);
    end
    tick();
    n_cmp++;
    if (bus.blockType !== 3'd3) begin
      n_bad++; $display("FAIL block_second: got %0d expected 3", bus.blockType);
    end
    bus.score = 32'd0;
  endtask

  task automatic test_gravity;
    int first = -1;
    int second = -1;
    int down_cnt = 0;
    int other_cnt = 0;
    do_reset();
    for (int n = 1; n <= 200; n++) begin
      tick();
      if (bus.downTrue) begin
        down_cnt++;
        if (first < 0) first = n;
        else if (second < 0) second = n;
      end
      if (strb() & 4'b0111) other_cnt++;
    end
    n_cmp++;
    if (first !== 65) begin
      n_bad++; $display("FAIL grav_first: got %0d expected 65", first);
    end
    n_cmp++;
    if (second !== 129) begin
      n_bad++; $display("FAIL grav_second: got %0d expected 129", second);
    end
    n_cmp++;
    if (down_cnt !== 3) begin
      n_bad++; $display("FAIL grav_width: got %0d high cycles expected 3", down_cnt);
    end
    n_cmp++;
    if (other_cnt !== 0) begin
      n_bad++; $display("FAIL grav_others: got %0d expected 0", other_cnt);
    end
  endtask

  task automatic test_priority;
    int t_r = -1, t_l = -1, t_o = -1;
    int c_r = 0, c_l = 0, c_o = 0, c_d = 0;
    do_reset();
    bus.btnLeft   = 1'b1;
    bus.btnRight  = 1'b1;
    bus.btnRotate = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (n == 12) begin
        bus.btnLeft   = 1'b0;
        bus.btnRight  = 1'b0;
        bus.btnRotate = 1'b0;
      end
      if (bus.rightTrue) begin c_r++; if (t_r < 0) t_r = n; end
      if (bus.leftTrue) begin c_l++; if (t_l < 0) t_l = n; end
      if (bus.rotateTrue) begin c_o++; if (t_o < 0) t_o = n; end
      if (bus.downTrue) c_d++;
    end
    n_cmp++;
    if (t_r !== 4) begin
      n_bad++; $display("FAIL prio_right_time: got %0d expected 4", t_r);
    end
    n_cmp++;
    if ((t_l - t_r < 2) || (t_l - t_r > 3)) begin
      n_bad++; $display("FAIL prio_left_gap: got %0d expected 2..3", t_l - t_r);
    end
    n_cmp++;
    if ((t_o - t_l < 2) || (t_o - t_l > 3)) begin
      n_bad++; $display("FAIL prio_rotate_gap: got %0d expected 2..3", t_o - t_l);
    end
    n_cmp++;
    if ({c_r, c_l, c_o, c_d} !== {32'd1, 32'd1, 32'd1, 32'd0}) begin
      n_bad++;
      $display("FAIL prio_counts: got r=%0d l=%0d o=%0d d=%0d expected 1 1 1 0",
               c_r, c_l, c_o, c_d);
    end
  endtask

  task automatic test_level;
    int          scores [4] = '{0, 10, 20, 35};
    int          periods[4] = '{64, 32, 16, 8};
    logic [1:0]  levels [4] = '{2'd0, 2'd1, 2'd2, 2'd3};
    int          p;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      bus.score = 32'(scores[k]);
      tick();
      n_cmp++;
      if (bus.level !== levels[k]) begin
        n_bad++; $display("FAIL level_%0d: got %0d expected %0d", scores[k], bus.level, levels[k]);
      end
      wait_down(p);
      wait_down(p);
      wait_down(p);
      n_cmp++;
      if (p !== periods[k]) begin
        n_bad++; $display("FAIL period_%0d: got %0d expected %0d", scores[k], p, periods[k]);
      end
    end
    bus.score = 32'd0;
  endtask

  task automatic test_soft_drop;
    int p;
    do_reset();
    bus.btnDown = 1'b1;
    wait_down(p);
    wait_down(p);
    wait_down(p);
    n_cmp++;
    if (p !== 8) begin
      n_bad++; $display("FAIL soft_period: got %0d expected 8", p);
    end
    bus.btnDown = 1'b0;
  endtask

  task automatic test_pause;
    int busy = 0;
    int t_o = -1, t_d = -1;
    bus.pause = 1'b1;
    do_reset();
    for (int n = 1; n <= 100; n++) begin
      tick();
      if (n == 10) bus.btnRotate = 1'b1;
      if (n == 20) bus.btnRotate = 1'b0;
      if (strb() != 4'b0000) busy++;
    end
    n_cmp++;
    if (busy !== 0) begin
      n_bad++; $display("FAIL pause_quiet: got %0d strobe cycles expected 0", busy);
    end
    bus.pause = 1'b0;
    for (int n = 1; n <= 100; n++) begin
      tick();
      if (bus.rotateTrue && t_o < 0) t_o = n;
      if (bus.downTrue && t_d < 0) t_d = n;
    end
    n_cmp++;
    if ((t_o < 1) || (t_o > 2)) begin
      n_bad++; $display("FAIL pause_rotate: got %0d expected 1..2", t_o);
    end
    n_cmp++;
    if (t_d !== 65) begin
      n_bad++; $display("FAIL pause_gravity: got %0d expected 65", t_d);
    end
  endtask

  task automatic test_lfsr;
    int         bad = 0;
    logic [7:0] seen = '0;
    do_reset();
    n_cmp++;
    if (bus.blockType !== 3'd0) begin
      n_bad++; $display("FAIL lfsr_reset: got %0d expected 0", bus.blockType);
    end
    for (int n = 0; n < 10000; n++) begin
      tick();
      if (bus.blockType > 3'd5) bad++;
      seen[bus.blockType] = 1'b1;
    end
    n_cmp++;
    if (bad !== 0) begin
      n_bad++; $display("FAIL lfsr_range: got %0d out-of-range cycles expected 0", bad);
    end
    n_cmp++;
    if (seen !== 8'h3f) begin
      n_bad++; $display("FAIL lfsr_coverage: got %h expected 3f", seen);
    end
  endtask

  task automatic test_mid_reset;
    int rot = 0;
    int t_d = -1;
    do_reset();
    bus.btnRotate = 1'b1;
    tick();
    tick();
    tick();
    // The next edge would enter ISSUE; make it a reset edge instead
    rst_n = 1'b0;
    bus.btnRotate = 1'b0;
    tick();
    n_cmp++;
    if (strb() !== 4'b0000) begin
      n_bad++; $display("FAIL midreset_strobe: got %b expected 0000", strb());
    end
    rst_n = 1'b1;
    for (int n = 1; n <= 70; n++) begin
      tick();
      if (bus.rotateTrue) rot++;
      if (bus.downTrue && t_d < 0) t_d = n;
    end
    n_cmp++;
    if (rot !== 0) begin
      n_bad++; $display("FAIL midreset_pending: got %0d rotate strobes expected 0", rot);
    end
    n_cmp++;
    if (t_d !== 65) begin
      n_bad++; $display("FAIL midreset_gravity: got %0d expected 65", t_d);
    end
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.btnLeft   = 1'b0;
    bus.btnRight  = 1'b0;
    bus.btnRotate = 1'b0;
    bus.btnDown   = 1'b0;
    bus.pause     = 1'b0;
    bus.score     = 32'd0;
    test_reset();
    test_gravity();
    test_priority();
    test_level();
    test_soft_drop();
    test_pause();
    test_lfsr();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
